// File: rtl/branch_control_path_if.sv
// Bus between the picoMIPS control path (master) and the program memory/datapath (slave).
interface branch_control_path_if #(
  parameter int N      = 8,
  parameter int A_SIZE = 3,
  parameter int O_SIZE = 6,
  parameter int P_SIZE = 5,
  parameter int R_SIZE = 3,
  parameter int I_SIZE = O_SIZE + R_SIZE + N
);

  logic [I_SIZE-1:0] instrIn;
  logic              zeroFlag;
  logic [9:0]        switchesIn;
  logic [P_SIZE-1:0] pmAddr;
  logic              writeReg;
  logic [A_SIZE-1:0] aluFunc;
  logic              aluImmediate;
  logic              immSwitches;
  logic [R_SIZE-1:0] opD;
  logic [N-1:0]      opS;
  logic [P_SIZE-1:0] displayPC;
  logic [O_SIZE-1:0] displayOpCode;
  logic              halted;

  modport master (
    input  instrIn, zeroFlag, switchesIn,
    output pmAddr, writeReg, aluFunc, aluImmediate, immSwitches,
           opD, opS, displayPC, displayOpCode, halted
  );

  modport slave (
    output instrIn, zeroFlag, switchesIn,
    input  pmAddr, writeReg, aluFunc, aluImmediate, immSwitches,
           opD, opS, displayPC, displayOpCode, halted
  );

endinterface

// File: rtl/branch_control_path.sv
// picoMIPS multicycle control path: FETCH/EXEC sequencer with jumps, zero-flag
// branches, a wait-for-switch stall and halt. Control outputs are live only in EXEC.
module branch_control_path #(
  parameter int N      = 8,
  parameter int A_SIZE = 3,
  parameter int O_SIZE = 6,
  parameter int P_SIZE = 5,
  parameter int R_SIZE = 3,
  parameter int I_SIZE = O_SIZE + R_SIZE + N
) (
  input logic                    clk,
  input logic                    reset,
  branch_control_path_if.master  bus
);

  localparam logic [O_SIZE-1:0] OP_JMP    = O_SIZE'(6'b010000);
  localparam logic [O_SIZE-1:0] OP_BEQ    = O_SIZE'(6'b010001);
  localparam logic [O_SIZE-1:0] OP_BNE    = O_SIZE'(6'b010010);
  localparam logic [O_SIZE-1:0] OP_LDSW   = O_SIZE'(6'b100000);
  localparam logic [O_SIZE-1:0] OP_WAITSW = O_SIZE'(6'b100001);
  localparam logic [O_SIZE-1:0] OP_HALT   = O_SIZE'(6'b111111);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t            r_state;
  logic [P_SIZE-1:0] r_pc;
  logic [I_SIZE-1:0] r_ir;
  logic              r_sw8Q;
  logic              r_writeReg;
  logic [A_SIZE-1:0] r_aluFunc;
  logic              r_aluImmediate;
  logic              r_immSwitches;
  logic              r_halted;

  logic [O_SIZE-1:0] w_fetchOp;
  logic [O_SIZE-1:0] w_irOp;
  logic              w_decWriteReg;
  logic [A_SIZE-1:0] w_decAluFunc;
  logic              w_decAluImm;
  logic              w_decImmSw;
  logic [P_SIZE-1:0] w_pcInc;
  logic [P_SIZE-1:0] w_target;
  logic [P_SIZE-1:0] w_branch;
  logic [P_SIZE-1:0] w_pcNext;
  logic              w_sw8Edge;
  logic              w_unusedSwitches;

  assign w_fetchOp = bus.instrIn[I_SIZE-1 -: O_SIZE];
  assign w_irOp    = r_ir[I_SIZE-1 -: O_SIZE];
  assign w_sw8Edge = bus.switchesIn[8] & ~r_sw8Q;

  // Only bit 8 steers the sequencer; the rest belong to the datapath.
  assign w_unusedSwitches = ^{bus.switchesIn[9], bus.switchesIn[7:0]};

  // Decode is done on the word being fetched so the control outputs can be
  // registered on the FETCH->EXEC edge and still appear exactly during EXEC.
  always_comb begin
    w_decWriteReg = 1'b0;
    w_decAluFunc  = '0;
    w_decAluImm   = 1'b0;
    w_decImmSw    = 1'b0;
    if (w_fetchOp[O_SIZE-1 -: 2] == 2'b00) begin
      w_decWriteReg = 1'b1;
      w_decAluImm   = w_fetchOp[3];
      w_decAluFunc  = w_fetchOp[A_SIZE-1:0];
    end else if (w_fetchOp == OP_LDSW) begin
      w_decWriteReg = 1'b1;
      w_decImmSw    = 1'b1;
    end
  end

  // Branch offsets are P_SIZE wide, so a plain modulo add equals PC + sext(offset).
  assign w_pcInc  = r_pc + P_SIZE'(1);
  assign w_target = r_ir[P_SIZE-1:0];
  assign w_branch = r_pc + w_target;

  always_comb begin
    w_pcNext = w_pcInc;
    case (w_irOp)
      OP_JMP:  w_pcNext = w_target;
      OP_BEQ:  w_pcNext = bus.zeroFlag ? w_branch : w_pcInc;
      OP_BNE:  w_pcNext = bus.zeroFlag ? w_pcInc : w_branch;
      OP_HALT: w_pcNext = r_pc;
      default: w_pcNext = w_pcInc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_FETCH;
      r_pc           <= '0;
      r_ir           <= '0;
      r_sw8Q         <= 1'b0;
      r_writeReg     <= 1'b0;
      r_aluFunc      <= '0;
      r_aluImmediate <= 1'b0;
      r_immSwitches  <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_sw8Q <= bus.switchesIn[8];
      case (r_state)
        S_FETCH: begin
          r_ir           <= bus.instrIn;
          r_writeReg     <= w_decWriteReg;
          r_aluFunc      <= w_decAluFunc;
          r_aluImmediate <= w_decAluImm;
          r_immSwitches  <= w_decImmSw;
          r_state        <= S_EXEC;
        end
        S_EXEC: begin
          r_writeReg     <= 1'b0;
          r_aluFunc      <= '0;
          r_aluImmediate <= 1'b0;
          r_immSwitches  <= 1'b0;
          r_pc           <= w_pcNext;
          if (w_irOp == OP_WAITSW) begin
            r_state <= S_WAIT;
          end else if (w_irOp == OP_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        // An edge seen during EXEC is already history here, so only edges inside WAIT release it.
        S_WAIT: begin
          if (w_sw8Edge) begin
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.pmAddr        = r_pc;
  assign bus.displayPC     = r_pc;
  assign bus.displayOpCode = w_irOp;
  assign bus.opD           = r_ir[N +: R_SIZE];
  assign bus.opS           = r_ir[N-1:0];
  assign bus.writeReg      = r_writeReg;
  assign bus.aluFunc       = r_aluFunc;
  assign bus.aluImmediate  = r_aluImmediate;
  assign bus.immSwitches   = r_immSwitches;
  assign bus.halted        = r_halted;

endmodule
